// File: rtl/cpu_debug_slave_sysclk_fifo.sv
// cpu_debug_slave_sysclk_fifo
//
// System-clock side of the CPU JTAG debug slave. Brings the TCK-domain
// update-IR / update-DR levels into clk, and queues every data update
// {ir, sr} in a small show-ahead command FIFO. Each popped entry produces a
// one-cycle, one-hot take_action / take_no_action strobe on its IR channel.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   vs_uir, vs_udr        TCK-domain update levels (asynchronous)
//   ir_in, sr             virtual IR value and data shift-register snapshot
//   cmd_valid/ready       head-of-queue handshake, cmd_ir / cmd_jdo payload
//   take_action           one-hot strobe, popped entry had jdo MSB = 1
//   take_no_action        one-hot strobe, popped entry had jdo MSB = 0
//   fifo_level            occupancy 0..2**FIFO_AW
//   overflow, ovf_clr     sticky dropped-update flag and its clear
module cpu_debug_slave_sysclk_fifo #(
    parameter int unsigned SR_W        = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned FIFO_AW     = 2,
    localparam int unsigned NUM_CH     = 2 ** IR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs_uir,
    input  logic              vs_udr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [SR_W-1:0]   sr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [SR_W-1:0]   cmd_jdo,
    output logic [NUM_CH-1:0] take_action,
    output logic [NUM_CH-1:0] take_no_action,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned EW    = IR_W + SR_W;

    // ---------------------------------------------------------------
    // Synchronisers and rising-edge detection
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
    // prime_q marks when the last sync stage holds a genuine sample rather
    // than the reset-cleared zero, so a level held high through reset
    // release is never mistaken for "seen low" and never arms.
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   uir_dly_q, udr_dly_q;
    logic                   uir_armed_q, udr_armed_q;
    logic                   uir_lvl, udr_lvl;
    logic                   uir_edge, udr_edge;

    assign uir_lvl  = uir_sync_q[SYNC_STAGES-1];
    assign udr_lvl  = udr_sync_q[SYNC_STAGES-1];
    assign uir_edge = uir_armed_q & uir_lvl & ~uir_dly_q;
    assign udr_edge = udr_armed_q & udr_lvl & ~udr_dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            uir_sync_q  <= '0;
            udr_sync_q  <= '0;
            prime_q     <= '0;
            uir_dly_q   <= 1'b0;
            udr_dly_q   <= 1'b0;
            uir_armed_q <= 1'b0;
            udr_armed_q <= 1'b0;
        end else begin
            uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            prime_q     <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            uir_dly_q   <= uir_lvl;
            udr_dly_q   <= udr_lvl;
            uir_armed_q <= uir_armed_q | (prime_q[SYNC_STAGES-1] & ~uir_lvl);
            udr_armed_q <= udr_armed_q | (prime_q[SYNC_STAGES-1] & ~udr_lvl);
        end
    end

    // ---------------------------------------------------------------
    // IR capture and command FIFO
    // ---------------------------------------------------------------
    logic [IR_W-1:0]    ir_reg_q;
    logic [IR_W-1:0]    push_ir;
    logic [EW-1:0]      mem_q [DEPTH];
    logic [EW-1:0]      head;
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               full, pop, push_ok, drop;
    logic [NUM_CH-1:0]  ta_q, ta_d, tna_q, tna_d;

    // A same-cycle uir edge must steer the push to the fresh IR value.
    assign push_ir = uir_edge ? ir_in : ir_reg_q;

    // Occupancy never exceeds DEPTH, so its MSB alone means full.
    assign full    = count_q[FIFO_AW];
    assign pop     = cmd_valid & cmd_ready;
    assign push_ok = udr_edge & (~full | pop);
    assign drop    = udr_edge & full & ~pop;

    assign head    = mem_q[rptr_q];
    assign cmd_ir  = head[EW-1 -: IR_W];
    assign cmd_jdo = head[SR_W-1:0];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        ta_d    = '0;
        tna_d   = '0;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
            if (cmd_jdo[SR_W-1]) begin
                ta_d[cmd_ir] = 1'b1;
            end else begin
                tna_d[cmd_ir] = 1'b1;
            end
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_reg_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ta_q     <= '0;
            tna_q    <= '0;
        end else begin
            if (uir_edge) begin
                ir_reg_q <= ir_in;
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ta_q    <= ta_d;
            tna_q   <= tna_d;
        end
    end

    // Storage needs no reset: entries are only visible while cmd_valid = 1.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem_q[wptr_q] <= {push_ir, sr};
        end
    end

    assign cmd_valid      = (count_q != '0);
    assign fifo_level     = count_q;
    assign overflow       = ovf_q;
    assign take_action    = ta_q;
    assign take_no_action = tna_q;

endmodule

// File: tb/tb_cpu_debug_slave_sysclk_fifo.sv
module tb_cpu_debug_slave_sysclk_fifo;

    logic        clk;
    logic        reset;
    logic        vs_uir;
    logic        vs_udr;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        ovf_clr;

    logic [2:0]  ir_in2;
    logic [63:0] sr2;
    logic        cmd_valid2;
    logic        cmd_ready2;
    logic [2:0]  cmd_ir2;
    logic [63:0] cmd_jdo2;
    logic [7:0]  ta2;
    logic [7:0]  tna2;
    logic [3:0]  lvl2;
    logic        ovf2;
    logic        ovf_clr2;

    int checks   = 0;
    int failures = 0;

    cpu_debug_slave_sysclk_fifo dut (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_jdo(cmd_jdo), .take_action(take_action),
        .take_no_action(take_no_action), .fifo_level(fifo_level),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    cpu_debug_slave_sysclk_fifo #(.SR_W(64), .IR_W(3)) dut_wide (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in2), .sr(sr2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_ir(cmd_ir2), .cmd_jdo(cmd_jdo2), .take_action(ta2),
        .take_no_action(tna2), .fifo_level(lvl2),
        .overflow(ovf2), .ovf_clr(ovf_clr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_uir(input logic [1:0] v);
        ir_in  = v;
        vs_uir = 1'b1;
        tick(3);
        vs_uir = 1'b0;
        tick(3);
    endtask

    task automatic pulse_udr(input logic [37:0] v);
        sr     = v;
        vs_udr = 1'b1;
        tick(3);
        vs_udr = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if (cmd_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0 ||
            take_action !== 4'b0 || take_no_action !== 4'b0) begin
            failures++;
            $display("FAIL reset_state got valid=%b lvl=%0d ovf=%b ta=%b tna=%b exp 0/0/0/0000/0000",
                     cmd_valid, fifo_level, overflow, take_action, take_no_action);
        end
        reset = 1'b0;
        tick(8);
    endtask

    task automatic test_basic();
        logic [37:0] v;
        v = 38'h20_0000_0001;
        pulse_uir(2'd2);
        cmd_ready = 1'b1;
        sr        = v;
        vs_udr    = 1'b1;
        tick(3);
        checks++;
        if (cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid_early got=%b exp=0", cmd_valid);
        end
        vs_udr = 1'b0;
        tick(1);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_ir !== 2'd2 || cmd_jdo !== v || fifo_level !== 3'd1) begin
            failures++;
            $display("FAIL basic_head got valid=%b ir=%0d jdo=%h lvl=%0d exp 1/2/%h/1",
                     cmd_valid, cmd_ir, cmd_jdo, fifo_level, v);
        end
        tick(1);
        checks++;
        if (take_action !== 4'b0100 || take_no_action !== 4'b0000 ||
            fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_strobe got ta=%b tna=%b lvl=%0d valid=%b exp 0100/0000/0/0",
                     take_action, take_no_action, fifo_level, cmd_valid);
        end
        tick(1);
        checks++;
        if (take_action !== 4'b0000) begin
            failures++;
            $display("FAIL basic_strobe_width got ta=%b exp=0000", take_action);
        end
        cmd_ready = 1'b0;
        tick(2);
    endtask

    task automatic test_overflow_drain();
        logic [37:0] d [5];
        d[0] = 38'h20_0000_0011;
        d[1] = 38'h00_0000_0022;
        d[2] = 38'h20_0000_0033;
        d[3] = 38'h00_0000_0044;
        d[4] = 38'h20_0000_0055;
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse_udr(d[i]);
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_fill got lvl=%0d ovf=%b exp 4/0", fifo_level, overflow);
        end
        pulse_udr(d[4]);
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drop got lvl=%0d ovf=%b exp 4/1", fifo_level, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_ir !== 2'd2 || cmd_jdo !== d[i]) begin
                failures++;
                $display("FAIL drain_head[%0d] got valid=%b ir=%0d jdo=%h exp 1/2/%h",
                         i, cmd_valid, cmd_ir, cmd_jdo, d[i]);
            end
            cmd_ready = 1'b1;
            tick(1);
            cmd_ready = 1'b0;
            checks++;
            if (take_action !== (d[i][37] ? 4'b0100 : 4'b0000) ||
                take_no_action !== (d[i][37] ? 4'b0000 : 4'b0100)) begin
                failures++;
                $display("FAIL drain_strobe[%0d] got ta=%b tna=%b msb=%b", i,
                         take_action, take_no_action, d[i][37]);
            end
        end
        checks++;
        if (fifo_level !== 3'd0 || cmd_valid !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL drain_empty got lvl=%0d valid=%b ovf=%b exp 0/0/1",
                     fifo_level, cmd_valid, overflow);
        end
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b exp=0", overflow);
        end
        tick(2);
    endtask

    task automatic test_full_push_pop();
        logic [37:0] e [5];
        for (int i = 0; i < 5; i++) e[i] = 38'h01_0000_0000 + 38'(i * 16 + 1);
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse_udr(e[i]);
        sr     = e[4];
        vs_udr = 1'b1;
        tick(3);
        cmd_ready = 1'b1;
        vs_udr    = 1'b0;
        tick(1);
        cmd_ready = 1'b0;
        checks++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0 || cmd_jdo !== e[1] ||
            take_no_action !== 4'b0100) begin
            failures++;
            $display("FAIL full_pushpop got lvl=%0d ovf=%b head=%h tna=%b exp 4/0/%h/0100",
                     fifo_level, overflow, cmd_jdo, take_no_action, e[1]);
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (cmd_jdo !== e[i] || cmd_valid !== 1'b1) begin
                failures++;
                $display("FAIL full_drain[%0d] got jdo=%h valid=%b exp %h/1",
                         i, cmd_jdo, cmd_valid, e[i]);
            end
            cmd_ready = 1'b1;
            tick(1);
            cmd_ready = 1'b0;
        end
        tick(2);
    endtask

    task automatic test_no_action_ovf_clr();
        pulse_uir(2'd1);
        cmd_ready = 1'b1;
        sr        = 38'h1F_FFFF_FFFF;
        vs_udr    = 1'b1;
        tick(3);
        vs_udr = 1'b0;
        tick(2);
        checks++;
        if (take_no_action !== 4'b0010 || take_action !== 4'b0000) begin
            failures++;
            $display("FAIL no_action got ta=%b tna=%b exp 0000/0010", take_action, take_no_action);
        end
        cmd_ready = 1'b0;
        tick(2);
        for (int i = 0; i < 4; i++) pulse_udr(38'h0A + 38'(i));
        sr     = 38'h0F;
        vs_udr = 1'b1;
        tick(3);
        ovf_clr = 1'b1;
        vs_udr  = 1'b0;
        tick(1);
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
            failures++;
            $display("FAIL ovf_set_priority got ovf=%b lvl=%0d exp 1/4", overflow, fifo_level);
        end
        tick(1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr_alone got=%b exp=0", overflow);
        end
        cmd_ready = 1'b1;
        tick(4);
        cmd_ready = 1'b0;
        checks++;
        if (fifo_level !== 3'd0) begin
            failures++;
            $display("FAIL t4_drain got lvl=%0d exp=0", fifo_level);
        end
        tick(2);
    endtask

    task automatic test_held_through_reset();
        vs_udr = 1'b1;
        reset  = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(10);
        checks++;
        if (fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL held_no_push got lvl=%0d valid=%b exp 0/0", fifo_level, cmd_valid);
        end
        vs_udr = 1'b0;
        tick(4);
        pulse_udr(38'h2A_5A5A_5A5A);
        checks++;
        if (fifo_level !== 3'd1 || cmd_jdo !== 38'h2A_5A5A_5A5A) begin
            failures++;
            $display("FAIL held_one_push got lvl=%0d jdo=%h exp 1/2a5a5a5a5a", fifo_level, cmd_jdo);
        end
    endtask

    task automatic test_reset_mid();
        pulse_udr(38'h20_0000_0101);
        pulse_udr(38'h20_0000_0202);
        checks++;
        if (fifo_level !== 3'd3) begin
            failures++;
            $display("FAIL mid_queued got lvl=%0d exp=3", fifo_level);
        end
        reset     = 1'b1;
        cmd_ready = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || fifo_level !== 3'd0 ||
            take_action !== 4'b0 || take_no_action !== 4'b0) begin
            failures++;
            $display("FAIL mid_reset got valid=%b lvl=%0d ta=%b tna=%b exp 0/0/0000/0000",
                     cmd_valid, fifo_level, take_action, take_no_action);
        end
        tick(1);
        checks++;
        if (take_action !== 4'b0 || take_no_action !== 4'b0) begin
            failures++;
            $display("FAIL mid_no_strobe got ta=%b tna=%b exp 0000/0000", take_action, take_no_action);
        end
        cmd_ready = 1'b0;
        tick(8);
    endtask

    task automatic test_wide_sweep();
        ir_in2 = 3'd5;
        pulse_uir(2'd0);
        sr2    = 64'h8000_0000_0000_0001;
        vs_udr = 1'b1;
        tick(3);
        vs_udr = 1'b0;
        tick(1);
        checks++;
        if (cmd_valid2 !== 1'b1 || cmd_ir2 !== 3'd5 || cmd_jdo2 !== 64'h8000_0000_0000_0001) begin
            failures++;
            $display("FAIL wide_head got valid=%b ir=%0d jdo=%h exp 1/5/8000000000000001",
                     cmd_valid2, cmd_ir2, cmd_jdo2);
        end
        tick(1);
        checks++;
        if (ta2 !== 8'b0010_0000 || tna2 !== 8'b0) begin
            failures++;
            $display("FAIL wide_action got ta=%b tna=%b exp 00100000/00000000", ta2, tna2);
        end
        tick(2);
        ir_in2 = 3'd6;
        pulse_uir(2'd0);
        sr2    = 64'h7FFF_FFFF_FFFF_FFFF;
        vs_udr = 1'b1;
        tick(3);
        vs_udr = 1'b0;
        tick(2);
        checks++;
        if (tna2 !== 8'b0100_0000 || ta2 !== 8'b0) begin
            failures++;
            $display("FAIL wide_no_action got ta=%b tna=%b exp 00000000/01000000", ta2, tna2);
        end
        tick(2);
    endtask

    initial begin
        reset      = 1'b1;
        vs_uir     = 1'b0;
        vs_udr     = 1'b0;
        ir_in      = '0;
        sr         = '0;
        cmd_ready  = 1'b0;
        ovf_clr    = 1'b0;
        ir_in2     = '0;
        sr2        = '0;
        cmd_ready2 = 1'b1;
        ovf_clr2   = 1'b0;
        tick(1);
        test_reset();
        test_basic();
        test_overflow_drain();
        test_full_push_pop();
        test_no_action_ovf_clr();
        test_held_through_reset();
        test_reset_mid();
        test_wide_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
